// File: rtl/pp_mac_accumulator_pkg.sv
// Shared types and arithmetic helpers for the Booth partial-product MAC.
// Widths are derived from the multsigned operand sizes.
package mac_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] sum;
  } sat_res_t;

  function automatic int unsigned pp_num_f(input int unsigned in_size_1);
    return (in_size_1 + 32'd2) / 32'd3;
  endfunction

  function automatic int unsigned pp_size_f(input int unsigned in_size_0,
                                            input int unsigned in_size_1);
    return in_size_0 + in_size_1;
  endfunction

  // Sign-extend the low w bits of v to MAX_W bits.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v,
                                            input int unsigned w);
    logic [MAX_W-1:0] t;
    t = v << (MAX_W - w);
    return MAX_W'($signed(t) >>> (MAX_W - w));
  endfunction

  // Add two sign-extended w-bit values, clamping to the w-bit signed range.
  function automatic sat_res_t sat_add(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int unsigned w);
    logic signed [MAX_W-1:0] s;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sat_res_t                r;
    s  = $signed(a) + $signed(b);
    hi = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    lo = ~hi;
    r.sum = s;
    r.sat = 1'b0;
    if (s > hi) begin
      r.sum = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_mac_accumulator_if.sv
// Beat input and result output handshakes of the partial-product MAC.
interface pp_mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int unsigned IN_SIZE_0 = 4,
  parameter int unsigned IN_SIZE_1 = 8,
  parameter int unsigned ACC_SIZE  = 32
);

  localparam int unsigned PP_NUM  = pp_num_f(IN_SIZE_1);
  localparam int unsigned PP_SIZE = pp_size_f(IN_SIZE_0, IN_SIZE_1);

  logic [PP_NUM-1:0][PP_SIZE-1:0] pp_i;
  logic                           pp_valid_i;
  logic                           pp_last_i;
  logic                           pp_ready_o;
  logic [ACC_SIZE-1:0]            acc_o;
  logic                           acc_valid_o;
  logic                           acc_ready_i;
  logic                           ovf_o;

  modport master (
    output pp_i, pp_valid_i, pp_last_i, acc_ready_i,
    input  pp_ready_o, acc_o, acc_valid_o, ovf_o
  );

  modport slave (
    input  pp_i, pp_valid_i, pp_last_i, acc_ready_i,
    output pp_ready_o, acc_o, acc_valid_o, ovf_o
  );

endinterface

// File: rtl/pp_reduce.sv
// Carry-save reduction of PP_NUM aligned partial products to one sum, mod 2^PP_SIZE.
module pp_reduce #(
  parameter int unsigned PP_NUM  = 3,
  parameter int unsigned PP_SIZE = 12
) (
  input  logic [PP_NUM-1:0][PP_SIZE-1:0] pp,
  output logic [PP_SIZE-1:0]             sum_c
);

  logic [PP_SIZE-1:0] s;
  logic [PP_SIZE-1:0] c;
  logic [PP_SIZE-1:0] t;

  // 3:2 compressor per operand keeps (s + c) equal to the running sum.
  always_comb begin
    s = '0;
    c = '0;
    t = '0;
    for (int k = 0; k < int'(PP_NUM); k++) begin
      t = s ^ c ^ pp[k];
      c = ((s & c) | (s & pp[k]) | (c & pp[k])) << 1;
      s = t;
    end
    sum_c = s + c;
  end

endmodule

// File: rtl/pp_mac_accumulator.sv
// Reduces Booth partial products per beat and accumulates dot products delimited by last.
// Optional saturation with sticky overflow flag: define PP_MAC_SAT_EN.
module pp_mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned IN_SIZE_0 = 4,
  parameter int unsigned IN_SIZE_1 = 8,
  parameter int unsigned ACC_SIZE  = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  pp_mac_accumulator_if.slave bus
);

  localparam int unsigned PP_NUM  = pp_num_f(IN_SIZE_1);
  localparam int unsigned PP_SIZE = pp_size_f(IN_SIZE_0, IN_SIZE_1);

  logic                s1_valid_q;
  logic                s1_last_q;
  logic [PP_SIZE-1:0]  s1_p_q;
  logic [PP_SIZE-1:0]  p1_c;

  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [ACC_SIZE-1:0] res_q, res_d;
  logic [ACC_SIZE-1:0] sum_c;
  logic                sticky_q, sticky_d;
  logic                ovf_q, ovf_d;
  logic                sat_c;
  acc_state_e          state_q, state_d;

  logic stall_c;
  logic pp_ready_c;
  logic s2_go_c;
  logic s2_last_c;

  pp_reduce #(
    .PP_NUM (PP_NUM),
    .PP_SIZE(PP_SIZE)
  ) u_reduce (
    .pp   (bus.pp_i),
    .sum_c(p1_c)
  );

  // A last beat in S1 may only move on once the output register can take it.
  assign stall_c    = s1_valid_q && s1_last_q && (state_q == OUT_FULL) && !bus.acc_ready_i;
  assign pp_ready_c = !s1_valid_q || !stall_c;
  assign s2_go_c    = s1_valid_q && !stall_c;
  assign s2_last_c  = s2_go_c && s1_last_q;

`ifdef PP_MAC_SAT_EN
  sat_res_t sat_res_c;

  always_comb begin
    sat_res_c = sat_add(sext(MAX_W'(acc_q), ACC_SIZE), sext(MAX_W'(s1_p_q), PP_SIZE), ACC_SIZE);
    sum_c     = ACC_SIZE'(sat_res_c.sum);
    sat_c     = sat_res_c.sat;
  end
`else
  always_comb begin
    sum_c = acc_q + ACC_SIZE'(sext(MAX_W'(s1_p_q), PP_SIZE));
    sat_c = 1'b0;
  end
`endif

  // S1: reduced product and last flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_p_q     <= '0;
    end else if (pp_ready_c) begin
      s1_valid_q <= bus.pp_valid_i;
      if (bus.pp_valid_i) begin
        s1_last_q <= bus.pp_last_i;
        s1_p_q    <= p1_c;
      end
    end
  end

  // S2 and output FSM state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= OUT_EMPTY;
      acc_q    <= '0;
      res_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    res_d    = res_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;

    case (state_q)
      OUT_EMPTY: if (s2_last_c) state_d = OUT_FULL;
      OUT_FULL:  if (bus.acc_ready_i && !s2_last_c) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase

    if (s2_go_c) begin
      if (s1_last_q) begin
        res_d    = sum_c;
        ovf_d    = sticky_q | sat_c;
        acc_d    = '0;
        sticky_d = 1'b0;
      end else begin
        acc_d    = sum_c;
        sticky_d = sticky_q | sat_c;
      end
    end
  end

  assign bus.pp_ready_o  = pp_ready_c;
  assign bus.acc_o       = res_q;
  assign bus.acc_valid_o = (state_q == OUT_FULL);
  assign bus.ovf_o       = ovf_q;

endmodule
